// File: rtl/ncl_dual_rail_tx.sv
`default_nettype none
// ============================================================================
// ncl_dual_rail_tx : clocked valid/ready words -> NCL dual-rail DATA/NULL
//                    wavefronts, paced by the receiver's completion ko
// Revision: 1.0
// ============================================================================
module ncl_dual_rail_tx #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             ko_i,
  output logic [WIDTH-1:0] out_t_o,
  output logic [WIDTH-1:0] out_f_o,
  output logic             busy_o,
  output logic             timeout_err_o,
  output logic [15:0]      wave_cnt_o
);

  localparam int            TW  = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT);

  typedef enum logic [1:0] {
    S_WAIT_RFD  = 2'd0,
    S_DATA      = 2'd1,
    S_NULL_WAIT = 2'd2
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [WIDTH-1:0]       out_t_q;
  logic [WIDTH-1:0]       out_f_q;
  logic [15:0]            wave_cnt_q;
  logic [TW-1:0]          timer_q;
  logic [TW-1:0]          timer_d;
  logic                   err_q;
  logic                   err_d;
  logic                   ko_s;
  logic                   accept;
  logic                   in_phase;
  logic                   phase_end;

  assign ko_s       = sync_q[SYNC_STAGES-1];
  assign in_ready_o = (state_q == S_WAIT_RFD) & ko_s;
  assign accept     = in_valid_i & in_ready_o;
  assign in_phase   = (state_q != S_WAIT_RFD);
  assign phase_end  = accept
                    | ((state_q == S_DATA)      & ~ko_s)
                    | ((state_q == S_NULL_WAIT) &  ko_s);

  // Timer saturates at TIMEOUT so a long stall cannot wrap and re-fire.
  always_comb begin
    timer_d = timer_q;
    err_d   = err_q;
    if (phase_end || !in_phase) begin
      timer_d = '0;
    end else if (timer_q != TMO) begin
      timer_d = timer_q + 1'b1;
      if (timer_d == TMO) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= S_WAIT_RFD;
      sync_q     <= '0;
      out_t_q    <= '0;
      out_f_q    <= '0;
      wave_cnt_q <= '0;
      timer_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ko_i};
      timer_q <= timer_d;
      err_q   <= err_d;
      case (state_q)
        S_WAIT_RFD: begin
          if (accept) begin
            out_t_q <= in_data_i;
            out_f_q <= ~in_data_i;
            state_q <= S_DATA;
          end
        end
        S_DATA: begin
          if (!ko_s) begin
            out_t_q    <= '0;
            out_f_q    <= '0;
            wave_cnt_q <= wave_cnt_q + 16'd1;
            state_q    <= S_NULL_WAIT;
          end
        end
        S_NULL_WAIT: begin
          if (ko_s) state_q <= S_WAIT_RFD;
        end
        default: begin
          out_t_q <= '0;
          out_f_q <= '0;
          state_q <= S_WAIT_RFD;
        end
      endcase
    end
  end

  assign out_t_o       = out_t_q;
  assign out_f_o       = out_f_q;
  assign busy_o        = in_phase;
  assign timeout_err_o = err_q;
  assign wave_cnt_o    = wave_cnt_q;

endmodule
`default_nettype wire
